// File: rtl/exc_ctrl.sv
// ---------------------------------------------------------------------------
// exc_ctrl -- sequential exception controller for the single-cycle LEGv8 core.
//
// This block latches external interrupt edges as pending requests. It
// prioritises them against the decoder's undefined-instruction flag. It also
// tracks handler entry and exit (ERET) and holds the cause (EStatus) and the
// return address (ELR) that MRS reads. It only decides when Exc fires and what
// gets recorded. Decoder control words do not pass through here.
//
// Parameters
//   N_IRQ  number of external interrupt lines (1..8)
//   PC_W   program counter / ELR width
//   ES_W   EStatus width
//
// Ports
//   clk         core clock
//   reset       asynchronous, active-high reset
//   ExtIRQ      level interrupt request lines, synchronous to clk
//   NotAnInstr  decoder flag: current instruction is undefined
//   ERet        decoder flag: current instruction is ERET
//   PC          address of the instruction in the current cycle
//   Exc         combinational: take exception this cycle (PC selects vector)
//   EStatus     registered exception cause
//   ELR         registered exception return address
//   InHandler   registered, high while in HANDLER
//   Halt        registered, high in LOCKED (core must stall the PC)
//   Pending     registered pending-interrupt bits
// ---------------------------------------------------------------------------
module exc_ctrl #(
  parameter int N_IRQ = 4,
  parameter int PC_W  = 64,
  parameter int ES_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ExtIRQ,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic [PC_W-1:0]  PC,
  output logic             Exc,
  output logic [ES_W-1:0]  EStatus,
  output logic [PC_W-1:0]  ELR,
  output logic             InHandler,
  output logic             Halt,
  output logic [N_IRQ-1:0] Pending
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [ES_W-1:0] ES_NONE  = ES_W'(0);
  localparam logic [ES_W-1:0] ES_UNDEF = ES_W'(2);
  localparam logic [ES_W-1:0] ES_DFLT  = ES_W'(3);

  state_t           state, state_nx;
  logic [N_IRQ-1:0] hist;
  logic [N_IRQ-1:0] irq_rise;
  logic [N_IRQ-1:0] take_oh;
  logic             take_nai;   // undefined instruction taken from RUN
  logic             take_irq;   // lowest pending interrupt taken from RUN
  logic             take_df;    // undefined instruction inside the handler
  logic             do_eret;    // handler return
  logic             exc_raw;

  // One-hot mask of the lowest set bit, so index 0 has the highest priority.
  function automatic logic [N_IRQ-1:0] lowest_one(input logic [N_IRQ-1:0] v);
    logic [N_IRQ-1:0] r;
    r = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  // Cause code 8+k for the lowest pending line k.
  function automatic logic [ES_W-1:0] irq_cause(input logic [N_IRQ-1:0] v);
    logic [ES_W-1:0] r;
    r = ES_NONE;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (v[i]) r = ES_W'(8 + i);
    end
    return r;
  endfunction

  assign irq_rise = ExtIRQ & ~hist;
  assign take_oh  = take_irq ? lowest_one(Pending) : '0;

  // ---- state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nx = state;
    case (state)
      RUN:     if (take_nai || take_irq) state_nx = HANDLER;
      HANDLER: begin
        if (take_df)      state_nx = LOCKED;
        else if (do_eret) state_nx = RUN;
      end
      LOCKED:  state_nx = LOCKED;
      default: state_nx = LOCKED;
    endcase
  end

  // ---- output / event decode ----
  // NotAnInstr outranks both interrupts (in RUN) and ERET (in HANDLER).
  always_comb begin
    take_nai = 1'b0;
    take_irq = 1'b0;
    take_df  = 1'b0;
    do_eret  = 1'b0;
    exc_raw  = 1'b0;
    case (state)
      RUN: begin
        if (NotAnInstr)    take_nai = 1'b1;
        else if (|Pending) take_irq = 1'b1;
        exc_raw = NotAnInstr | (|Pending);
      end
      HANDLER: begin
        if (NotAnInstr) take_df = 1'b1;
        else if (ERet)  do_eret = 1'b1;
        exc_raw = NotAnInstr;
      end
      default: ;
    endcase
  end

  // The registered state is already RUN during reset. NotAnInstr is live,
  // though, so Exc must be masked explicitly.
  assign Exc = exc_raw & ~reset;

  // ---- status registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      Pending   <= '0;
      EStatus   <= ES_NONE;
      ELR       <= '0;
      InHandler <= 1'b0;
      Halt      <= 1'b0;
    end else begin
      hist      <= ExtIRQ;
      // A fresh edge on the line being taken wins over its clear.
      Pending   <= (Pending & ~take_oh) | irq_rise;
      InHandler <= (state_nx == HANDLER);
      Halt      <= (state_nx == LOCKED);
      if (take_nai) begin
        EStatus <= ES_UNDEF;
        ELR     <= PC;
      end else if (take_irq) begin
        // The interrupted instruction is re-executed after ERET.
        EStatus <= irq_cause(Pending);
        ELR     <= PC;
      end else if (take_df) begin
        EStatus <= ES_DFLT;
      end else if (do_eret) begin
        EStatus <= ES_NONE;
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exc_ctrl -- scoreboard bench for exc_ctrl.
// Each driven cycle pushes the outputs expected during that cycle. A monitor
// pops them on the falling edge, once the inputs and registers have settled.
// ---------------------------------------------------------------------------
module tb_exc_ctrl;

  localparam int N_IRQ = 4;
  localparam int PC_W  = 64;
  localparam int ES_W  = 4;

  logic             clk;
  logic             reset;
  logic [N_IRQ-1:0] ExtIRQ;
  logic             NotAnInstr;
  logic             ERet;
  logic [PC_W-1:0]  PC;
  logic             Exc;
  logic [ES_W-1:0]  EStatus;
  logic [PC_W-1:0]  ELR;
  logic             InHandler;
  logic             Halt;
  logic [N_IRQ-1:0] Pending;

  exc_ctrl #(.N_IRQ(N_IRQ), .PC_W(PC_W), .ES_W(ES_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ExtIRQ     (ExtIRQ),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .PC         (PC),
    .Exc        (Exc),
    .EStatus    (EStatus),
    .ELR        (ELR),
    .InHandler  (InHandler),
    .Halt       (Halt),
    .Pending    (Pending)
  );

  typedef struct {
    int                id;
    logic              exc;
    logic [ES_W-1:0]   es;
    logic [PC_W-1:0]   elr;
    logic              inh;
    logic              halt;
    logic [N_IRQ-1:0]  pend;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected in that cycle.
  task automatic step(input logic [N_IRQ-1:0] irq, input logic nai, input logic eret,
                      input logic [PC_W-1:0] pc, input logic e_exc, input logic [ES_W-1:0] e_es,
                      input logic [PC_W-1:0] e_elr, input logic e_inh, input logic e_halt,
                      input logic [N_IRQ-1:0] e_pend);
    exp_t e;
    @(posedge clk);
    #2;
    ExtIRQ     = irq;
    NotAnInstr = nai;
    ERet       = eret;
    PC         = pc;
    step_id++;
    e.id = step_id; e.exc = e_exc; e.es = e_es; e.elr = e_elr;
    e.inh = e_inh; e.halt = e_halt; e.pend = e_pend;
    q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " Exc"},       64'(Exc),       64'd0);
    check({tag, " EStatus"},   64'(EStatus),   64'd0);
    check({tag, " ELR"},       ELR,            64'd0);
    check({tag, " InHandler"}, 64'(InHandler), 64'd0);
    check({tag, " Halt"},      64'(Halt),      64'd0);
    check({tag, " Pending"},   64'(Pending),   64'd0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      string t;
      e = q.pop_front();
      t = $sformatf("step%0d", e.id);
      check({t, " Exc"},       64'(Exc),       64'(e.exc));
      check({t, " EStatus"},   64'(EStatus),   64'(e.es));
      check({t, " ELR"},       ELR,            e.elr);
      check({t, " InHandler"}, 64'(InHandler), 64'(e.inh));
      check({t, " Halt"},      64'(Halt),      64'(e.halt));
      check({t, " Pending"},   64'(Pending),   64'(e.pend));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    ExtIRQ     = '0;
    NotAnInstr = 1'b1;   // Exc must stay low while reset is high
    ERet       = 1'b0;
    PC         = '0;
    #12;
    check_all_zero("reset");
    NotAnInstr = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;

    // IRQ 2 edge, level held: one request only
    step(4'h0, 0, 0, 64'h40, 0, 4'h0, 64'h00, 0, 0, 4'h0);
    step(4'h4, 0, 0, 64'h40, 0, 4'h0, 64'h00, 0, 0, 4'h0);
    step(4'h4, 0, 0, 64'h40, 1, 4'h0, 64'h00, 0, 0, 4'h4);
    step(4'h4, 0, 0, 64'h44, 0, 4'hA, 64'h40, 1, 0, 4'h0);
    step(4'h0, 0, 0, 64'h48, 0, 4'hA, 64'h40, 1, 0, 4'h0);
    step(4'h0, 0, 1, 64'h4C, 0, 4'hA, 64'h40, 1, 0, 4'h0);
    step(4'h0, 0, 0, 64'h60, 0, 4'h0, 64'h40, 0, 0, 4'h0);
    // NotAnInstr outranks pending 0011; IRQ 0 taken right after ERET
    step(4'h3, 0, 0, 64'h70, 0, 4'h0, 64'h40, 0, 0, 4'h0);
    step(4'h3, 1, 0, 64'h80, 1, 4'h0, 64'h40, 0, 0, 4'h3);
    step(4'h0, 0, 1, 64'h84, 0, 4'h2, 64'h80, 1, 0, 4'h3);
    step(4'h0, 0, 0, 64'h88, 1, 4'h0, 64'h80, 0, 0, 4'h3);
    step(4'h0, 0, 1, 64'h8C, 0, 4'h8, 64'h88, 1, 0, 4'h2);
    step(4'h0, 0, 0, 64'h90, 1, 4'h0, 64'h88, 0, 0, 4'h2);
    // Edges on IRQ 3 and 1 while in the handler accumulate without Exc
    step(4'hA, 0, 0, 64'h94, 0, 4'h9, 64'h90, 1, 0, 4'h0);
    step(4'h0, 0, 0, 64'h98, 0, 4'h9, 64'h90, 1, 0, 4'hA);
    step(4'h0, 0, 1, 64'h9C, 0, 4'h9, 64'h90, 1, 0, 4'hA);
    step(4'h0, 0, 0, 64'hA0, 1, 4'h0, 64'h90, 0, 0, 4'hA);
    step(4'h0, 0, 1, 64'hA4, 0, 4'h9, 64'hA0, 1, 0, 4'h8);
    step(4'h0, 0, 0, 64'hB0, 1, 4'h0, 64'hA0, 0, 0, 4'h8);
    // Double fault locks; IRQ/ERET/NotAnInstr then do nothing, edges still captured
    step(4'h0, 1, 0, 64'hB4, 1, 4'hB, 64'hB0, 1, 0, 4'h0);
    step(4'h1, 0, 1, 64'hB8, 0, 4'h3, 64'hB0, 0, 1, 4'h0);
    step(4'h1, 1, 0, 64'hBC, 0, 4'h3, 64'hB0, 0, 1, 4'h1);

    // Asynchronous reset out of LOCKED
    @(negedge clk); #1;
    check("locked Halt before reset", 64'(Halt), 64'd1);
    ExtIRQ = '0; NotAnInstr = 1'b0; ERet = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("async reset from LOCKED");
    @(posedge clk); #2;
    reset = 1'b0;

    // Enter handler with a pending IRQ, then reset mid-cycle
    step(4'h0, 1, 0, 64'h200, 1, 4'h0, 64'h000, 0, 0, 4'h0);
    step(4'h1, 0, 0, 64'h204, 0, 4'h2, 64'h200, 1, 0, 4'h0);
    step(4'h0, 0, 0, 64'h208, 0, 4'h2, 64'h200, 1, 0, 4'h1);
    @(negedge clk); #1;
    check("handler InHandler before reset", 64'(InHandler), 64'd1);
    reset = 1'b1;
    #1;
    check_all_zero("async reset from HANDLER");
    @(posedge clk); #2;
    reset = 1'b0;

    // ERET in RUN with nothing pending changes nothing
    step(4'h0, 0, 1, 64'h300, 0, 4'h0, 64'h000, 0, 0, 4'h0);
    step(4'h0, 0, 0, 64'h304, 0, 4'h0, 64'h000, 0, 0, 4'h0);
    // New edge on the line being taken keeps its pending bit set
    step(4'h0, 1, 0, 64'h320, 1, 4'h0, 64'h000, 0, 0, 4'h0);
    step(4'h1, 0, 0, 64'h324, 0, 4'h2, 64'h320, 1, 0, 4'h0);
    step(4'h0, 0, 1, 64'h328, 0, 4'h2, 64'h320, 1, 0, 4'h1);
    step(4'h1, 0, 0, 64'h330, 1, 4'h0, 64'h320, 0, 0, 4'h1);
    step(4'h1, 0, 1, 64'h334, 0, 4'h8, 64'h330, 1, 0, 4'h1);
    step(4'h0, 0, 0, 64'h340, 1, 4'h0, 64'h330, 0, 0, 4'h1);
    // ERET and NotAnInstr together in the handler: double fault wins
    step(4'h0, 1, 1, 64'h350, 1, 4'h8, 64'h340, 1, 0, 4'h0);
    step(4'h0, 0, 0, 64'h354, 0, 4'h3, 64'h340, 0, 1, 4'h0);

    @(negedge clk); #1;
    check("scoreboard drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
